// File: rtl/branch_update_queue_if.sv
// Execute-to-predictor branch update bundle: two resolved-branch enqueue slots in,
// two Gshare update slots out, plus flush/hold/stall handshake.
interface branch_update_queue_if #(
  parameter int IDXW = 4
) ();
  logic            flush;
  logic            upd_hold;
  logic            uq_stall;

  logic            exA_valid,       exB_valid;
  logic [63:0]     exA_PC,          exB_PC;
  logic [63:0]     exA_target,      exB_target;
  logic [63:0]     exA_pred_target, exB_pred_target;
  logic [IDXW-1:0] exA_pht_idx,     exB_pht_idx;
  logic            exA_taken,       exB_taken;
  logic            exA_pred_taken,  exB_pred_taken;

  logic            Gshare_update_enA,        Gshare_update_enB;
  logic [63:0]     branch_PCA,               branch_PCB;
  logic [63:0]     branch_target_PCA,        branch_target_PCB;
  logic [IDXW-1:0] branch_PHT_idxA,          branch_PHT_idxB;
  logic            previous_true_resultA,    previous_true_resultB;
  logic            previous_predict_resultA, previous_predict_resultB;
  logic            need_take_branchA,        need_take_branchB;
  logic            mispredict_branchA,       mispredict_branchB;

  modport master (
    output flush, upd_hold,
    output exA_valid, exB_valid, exA_PC, exB_PC, exA_target, exB_target,
    output exA_pred_target, exB_pred_target, exA_pht_idx, exB_pht_idx,
    output exA_taken, exB_taken, exA_pred_taken, exB_pred_taken,
    input  uq_stall, Gshare_update_enA, Gshare_update_enB,
    input  branch_PCA, branch_PCB, branch_target_PCA, branch_target_PCB,
    input  branch_PHT_idxA, branch_PHT_idxB,
    input  previous_true_resultA, previous_true_resultB,
    input  previous_predict_resultA, previous_predict_resultB,
    input  need_take_branchA, need_take_branchB,
    input  mispredict_branchA, mispredict_branchB
  );

  modport slave (
    input  flush, upd_hold,
    input  exA_valid, exB_valid, exA_PC, exB_PC, exA_target, exB_target,
    input  exA_pred_target, exB_pred_target, exA_pht_idx, exB_pht_idx,
    input  exA_taken, exB_taken, exA_pred_taken, exB_pred_taken,
    output uq_stall, Gshare_update_enA, Gshare_update_enB,
    output branch_PCA, branch_PCB, branch_target_PCA, branch_target_PCB,
    output branch_PHT_idxA, branch_PHT_idxB,
    output previous_true_resultA, previous_true_resultB,
    output previous_predict_resultA, previous_predict_resultB,
    output need_take_branchA, need_take_branchB,
    output mispredict_branchA, mispredict_branchB
  );
endinterface

// File: rtl/branch_update_queue.sv
// Dual-ported circular queue buffering resolved branches from execute until the
// Gshare predictor can absorb them, two per cycle, oldest first.
module branch_update_queue #(
  parameter int DEPTH = 8,
  parameter int IDXW  = 4
) (
  input logic clock,
  input logic reset,
  branch_update_queue_if.slave bus
);
  localparam int PTRW = $clog2(DEPTH);
  localparam int CNTW = PTRW + 1;
  localparam logic [CNTW-1:0] DEPTH_C = CNTW'(DEPTH);

  typedef struct packed {
    logic [63:0]     pc;
    logic [63:0]     target;
    logic [IDXW-1:0] idx;
    logic            taken;
    logic            pred_taken;
    logic            need_take;
    logic            mispredict;
  } entry_t;

  entry_t          mem_q [DEPTH];
  logic [PTRW-1:0] head_q, head_d, tail_q, tail_d, wr_b_ptr, head_p1;
  logic [CNTW-1:0] count_q, count_d, free;
  logic            acc_a, acc_b, en_a, en_b;
  entry_t          ent_a, ent_b, out_a, out_b;

  function automatic entry_t mk_entry(input logic [63:0] pc, input logic [63:0] tgt,
                                      input logic [63:0] ptgt, input logic [IDXW-1:0] idx,
                                      input logic tk, input logic ptk);
    entry_t e;
    e.pc         = pc;
    e.target     = tgt;
    e.idx        = idx;
    e.taken      = tk;
    e.pred_taken = ptk;
    e.need_take  = tk & (!ptk | (tgt != ptgt));
    e.mispredict = ptk & !tk;
    return e;
  endfunction

  always_comb begin
    ent_a = mk_entry(bus.exA_PC, bus.exA_target, bus.exA_pred_target,
                     bus.exA_pht_idx, bus.exA_taken, bus.exA_pred_taken);
    ent_b = mk_entry(bus.exB_PC, bus.exB_target, bus.exB_pred_target,
                     bus.exB_pht_idx, bus.exB_taken, bus.exB_pred_taken);
  end

  // Room is judged on the registered count only; a same-cycle dequeue frees nothing.
  always_comb begin
    free     = DEPTH_C - count_q;
    acc_a    = bus.exA_valid && (free != '0);
    acc_b    = bus.exB_valid && (bus.exA_valid ? (free >= CNTW'(2)) : (free != '0));
    wr_b_ptr = acc_a ? tail_q + PTRW'(1) : tail_q;
    en_a     = !bus.upd_hold && (count_q >= CNTW'(1));
    en_b     = !bus.upd_hold && (count_q >= CNTW'(2));
    head_p1  = head_q + PTRW'(1);

    if (bus.flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + PTRW'(en_a) + PTRW'(en_b);
      tail_d  = tail_q + PTRW'(acc_a) + PTRW'(acc_b);
      count_d = count_q + CNTW'(acc_a) + CNTW'(acc_b) - CNTW'(en_a) - CNTW'(en_b);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage carries no reset; validity is tracked entirely by count_q.
  always_ff @(posedge clock) begin
    if (!bus.flush) begin
      if (acc_a) mem_q[tail_q]   <= ent_a;
      if (acc_b) mem_q[wr_b_ptr] <= ent_b;
    end
  end

  always_comb begin
    out_a = en_a ? mem_q[head_q]  : '0;
    out_b = en_b ? mem_q[head_p1] : '0;
  end

  assign bus.uq_stall                 = (free < CNTW'(2));
  assign bus.Gshare_update_enA        = en_a;
  assign bus.Gshare_update_enB        = en_b;
  assign bus.branch_PCA               = out_a.pc;
  assign bus.branch_PCB               = out_b.pc;
  assign bus.branch_target_PCA        = out_a.target;
  assign bus.branch_target_PCB        = out_b.target;
  assign bus.branch_PHT_idxA          = out_a.idx;
  assign bus.branch_PHT_idxB          = out_b.idx;
  assign bus.previous_true_resultA    = out_a.taken;
  assign bus.previous_true_resultB    = out_b.taken;
  assign bus.previous_predict_resultA = out_a.pred_taken;
  assign bus.previous_predict_resultB = out_b.pred_taken;
  assign bus.need_take_branchA        = out_a.need_take;
  assign bus.need_take_branchB        = out_b.need_take;
  assign bus.mispredict_branchA       = out_a.mispredict;
  assign bus.mispredict_branchB       = out_b.mispredict;
endmodule

// File: tb/tb_branch_update_queue.sv
// Scoreboard bench for branch_update_queue: expected entries are queued as they are
// driven and compared against both update slots every cycle.
module tb_branch_update_queue;
  localparam int DEPTH = 8;
  localparam int IDXW  = 4;

  typedef struct packed {
    logic [63:0]     pc;
    logic [63:0]     tgt;
    logic [IDXW-1:0] idx;
    logic            tk;
    logic            ptk;
    logic            nt;
    logic            mp;
  } ent_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;
  ent_t sb[$];

  branch_update_queue_if #(.IDXW(IDXW)) bus ();

  branch_update_queue #(.DEPTH(DEPTH), .IDXW(IDXW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk_val(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic ent_t mk(input logic [63:0] pc, input logic [63:0] tgt, input logic [63:0] ptgt,
                              input logic [IDXW-1:0] idx, input logic tk, input logic ptk);
    ent_t e;
    e.pc  = pc;
    e.tgt = tgt;
    e.idx = idx;
    e.tk  = tk;
    e.ptk = ptk;
    e.nt  = tk && (!ptk || (tgt != ptgt));
    e.mp  = ptk && !tk;
    return e;
  endfunction

  task automatic set_a(input logic v, input logic [63:0] pc, input logic [63:0] tgt, input logic [63:0] ptgt,
                       input logic [IDXW-1:0] idx, input logic tk, input logic ptk);
    bus.exA_valid = v; bus.exA_PC = pc; bus.exA_target = tgt; bus.exA_pred_target = ptgt;
    bus.exA_pht_idx = idx; bus.exA_taken = tk; bus.exA_pred_taken = ptk;
  endtask

  task automatic set_b(input logic v, input logic [63:0] pc, input logic [63:0] tgt, input logic [63:0] ptgt,
                       input logic [IDXW-1:0] idx, input logic tk, input logic ptk);
    bus.exB_valid = v; bus.exB_PC = pc; bus.exB_target = tgt; bus.exB_pred_target = ptgt;
    bus.exB_pht_idx = idx; bus.exB_taken = tk; bus.exB_pred_taken = ptk;
  endtask

  task automatic rnd_a(input logic v);
    logic [63:0] t;
    t = {$urandom, $urandom};
    set_a(v, {$urandom, $urandom}, t, ($urandom_range(1) != 0) ? t : {$urandom, $urandom},
          IDXW'($urandom), 1'($urandom), 1'($urandom));
  endtask

  task automatic rnd_b(input logic v);
    logic [63:0] t;
    t = {$urandom, $urandom};
    set_b(v, {$urandom, $urandom}, t, ($urandom_range(1) != 0) ? t : {$urandom, $urandom},
          IDXW'($urandom), 1'($urandom), 1'($urandom));
  endtask

  task automatic check_outputs(input string tag);
    ent_t exp_a, exp_b, obs_a, obs_b;
    logic ea, eb;
    ea    = !bus.upd_hold && (sb.size() >= 1);
    eb    = !bus.upd_hold && (sb.size() >= 2);
    exp_a = ea ? sb[0] : '0;
    exp_b = eb ? sb[1] : '0;
    obs_a = {bus.branch_PCA, bus.branch_target_PCA, bus.branch_PHT_idxA, bus.previous_true_resultA,
             bus.previous_predict_resultA, bus.need_take_branchA, bus.mispredict_branchA};
    obs_b = {bus.branch_PCB, bus.branch_target_PCB, bus.branch_PHT_idxB, bus.previous_true_resultB,
             bus.previous_predict_resultB, bus.need_take_branchB, bus.mispredict_branchB};
    chk_val({tag, "_enA"}, 192'(bus.Gshare_update_enA), 192'(ea));
    chk_val({tag, "_enB"}, 192'(bus.Gshare_update_enB), 192'(eb));
    chk_val({tag, "_stall"}, 192'(bus.uq_stall), 192'((DEPTH - sb.size()) < 2));
    chk_val({tag, "_slotA"}, 192'(obs_a), 192'(exp_a));
    chk_val({tag, "_slotB"}, 192'(obs_b), 192'(exp_b));
  endtask

  task automatic model_update();
    int   sz, fr, nd;
    logic acc_a, acc_b;
    sz = sb.size();
    fr = DEPTH - sz;
    if (bus.flush) begin
      sb.delete();
    end else begin
      nd = bus.upd_hold ? 0 : ((sz >= 2) ? 2 : sz);
      for (int i = 0; i < nd; i++) void'(sb.pop_front());
      acc_a = bus.exA_valid && (fr >= 1);
      acc_b = bus.exB_valid && (bus.exA_valid ? (fr >= 2) : (fr >= 1));
      if (acc_a) sb.push_back(mk(bus.exA_PC, bus.exA_target, bus.exA_pred_target,
                                 bus.exA_pht_idx, bus.exA_taken, bus.exA_pred_taken));
      if (acc_b) sb.push_back(mk(bus.exB_PC, bus.exB_target, bus.exB_pred_target,
                                 bus.exB_pht_idx, bus.exB_taken, bus.exB_pred_taken));
    end
  endtask

  task automatic step(input string tag);
    #1;
    check_outputs(tag);
    model_update();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    bus.exA_valid = 1'b0;
    bus.exB_valid = 1'b0;
    bus.flush     = 1'b0;
  endtask

  task automatic drain(input string tag);
    idle();
    bus.upd_hold = 1'b0;
    for (int i = 0; i < 2 * DEPTH && sb.size() > 0; i++) step(tag);
    step(tag);
    chk_val({tag, "_empty"}, 192'(sb.size()), 192'(0));
  endtask

  initial begin
    bus.upd_hold = 1'b0;
    idle();
    rnd_a(1'b0);
    rnd_b(1'b0);
    #3;
    check_outputs("reset");
    @(posedge clock);
    #2 reset = 1'b0;
    @(posedge clock);
    #1;
    step("post_reset");

    set_a(1'b1, 64'h100, 64'h200, 64'h0, 4'd5, 1'b1, 1'b0);
    step("single_enq");
    idle();
    #1;
    chk_val("single_nt",  192'(bus.need_take_branchA),  192'(1));
    chk_val("single_mp",  192'(bus.mispredict_branchA), 192'(0));
    chk_val("single_idx", 192'(bus.branch_PHT_idxA),    192'(5));
    step("single_deq");
    step("single_done");

    bus.upd_hold = 1'b1;
    rnd_a(1'b1);
    rnd_b(1'b1);
    step("dual_enq");
    idle();
    step("hold1");
    step("hold2");
    bus.upd_hold = 1'b0;
    step("release");
    step("released");

    set_a(1'b1, 64'h1000, 64'h340, 64'h300, 4'd9, 1'b1, 1'b1);
    set_b(1'b1, 64'h1004, 64'h340, 64'h300, 4'd3, 1'b0, 1'b1);
    step("tgt_enq");
    idle();
    #1;
    chk_val("tgt_ntA", 192'(bus.need_take_branchA),  192'(1));
    chk_val("tgt_mpA", 192'(bus.mispredict_branchA), 192'(0));
    chk_val("tgt_ntB", 192'(bus.need_take_branchB),  192'(0));
    chk_val("tgt_mpB", 192'(bus.mispredict_branchB), 192'(1));
    step("tgt_deq");

    bus.upd_hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rnd_a(1'b1);
      rnd_b(1'b1);
      step("fill");
    end
    rnd_a(1'b1);
    rnd_b(1'b0);
    step("fill7");
    idle();
    #1;
    chk_val("fill7_stall", 192'(bus.uq_stall), 192'(1));
    rnd_a(1'b1);
    rnd_b(1'b1);
    step("fill_partial");
    rnd_a(1'b1);
    rnd_b(1'b1);
    step("fill_full");
    chk_val("full_count", 192'(sb.size()), 192'(DEPTH));
    idle();
    step("full_idle");
    drain("full_drain");

    for (int i = 0; i < 80; i++) begin
      bus.upd_hold = ($urandom_range(2) == 0);
      rnd_a(1'($urandom));
      rnd_b(1'($urandom));
      step("rand");
    end
    drain("rand_drain");

    bus.upd_hold = 1'b1;
    rnd_a(1'b1); rnd_b(1'b1); step("pre_flush");
    rnd_a(1'b1); rnd_b(1'b1); step("pre_flush");
    rnd_a(1'b1); rnd_b(1'b0); step("pre_flush");
    bus.upd_hold = 1'b0;
    bus.flush    = 1'b1;
    rnd_a(1'b1);
    rnd_b(1'b1);
    step("flush");
    idle();
    #1;
    chk_val("flush_enA", 192'(bus.Gshare_update_enA), 192'(0));
    chk_val("flush_enB", 192'(bus.Gshare_update_enB), 192'(0));
    step("post_flush");

    bus.upd_hold = 1'b1;
    rnd_a(1'b1); rnd_b(1'b1); step("pre_reset");
    rnd_a(1'b1); rnd_b(1'b0); step("pre_reset");
    idle();
    bus.upd_hold = 1'b0;
    #1;
    chk_val("pre_reset_enA", 192'(bus.Gshare_update_enA), 192'(1));
    #2 reset = 1'b1;
    #1;
    sb.delete();
    check_outputs("async_reset");
    #1 reset = 1'b0;
    @(posedge clock);
    #1;
    set_a(1'b1, 64'hABC0, 64'hABD0, 64'hABD0, 4'd2, 1'b1, 1'b1);
    set_b(1'b1, 64'hABC4, 64'hAB00, 64'hABD0, 4'd7, 1'b1, 1'b1);
    step("after_reset_enq");
    drain("after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/branch_update_queue.md
BRANCH_UPDATE_QUEUE -- requirements
Module: branch_update_queue

Interface
REQ-001 Parameter DEPTH, default 8, queue entries (power of two, >=4).
REQ-002 Parameter IDXW, default 4, PHT index width; equals predictor BHR width.
REQ-003 clock  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-005 flush  in  1  discard all queued entries at next edge.
REQ-006 exA_valid / exB_valid  in  1 each  resolved branch present on slot A / B; A is older than B.
REQ-007 exA_PC / exB_PC  in  64 each  branch instruction PC.
REQ-008 exA_target / exB_target  in  64 each  computed target PC.
REQ-009 exA_pred_target / exB_pred_target  in  64 each  target used at fetch.
REQ-010 exA_pht_idx / exB_pht_idx  in  IDXW each  PHT index captured at fetch.
REQ-011 exA_taken / exB_taken  in  1 each  actual outcome.
REQ-012 exA_pred_taken / exB_pred_taken  in  1 each  predicted outcome.
REQ-013 upd_hold  in  1  predictor cannot accept updates this cycle.
REQ-014 uq_stall  out  1  fewer than 2 free entries; execute must not issue branches.
REQ-015 Gshare_update_enA / Gshare_update_enB  out  1 each  update slot valid.
REQ-016 branch_PCA/B, branch_target_PCA/B  out  64 each; branch_PHT_idxA/B  out  IDXW each.
REQ-017 previous_true_resultA/B, previous_predict_resultA/B, need_take_branchA/B, mispredict_branchA/B  out  1 each.

Function
REQ-018 Circular buffer: head pointer, tail pointer, count (0..DEPTH, width log2(DEPTH)+1); pointers wrap modulo DEPTH.
REQ-019 Free = DEPTH - count, computed from registered count only; same-cycle dequeue does not create room.
REQ-020 Enqueue order: A written at tail, B at tail+1 when both valid; B alone written at tail; tail advances by number accepted.
REQ-021 Capacity: free>=2 accepts both; free==1 accepts A only (or B if A invalid), other dropped; free==0 accepts none.
REQ-022 uq_stall = (free < 2), combinational from registered count.
REQ-023 Stored per entry: PC, target, pht_idx, taken, pred_taken, need_take = taken & (!pred_taken | target != pred_target), mispredict = pred_taken & !taken.
REQ-024 Latency: entry enqueued at edge N visible on outputs from cycle N+1 (no same-cycle bypass).
REQ-025 Dequeue: when !upd_hold, slot A presents head entry if count>=1, slot B presents head+1 if count>=2; head advances by slots presented.
REQ-026 Gshare_update_enA = !upd_hold & count>=1; Gshare_update_enB = !upd_hold & count>=2.
REQ-027 All slot data outputs driven to 0 when corresponding Gshare_update_en is 0.
REQ-028 Simultaneous enqueue and dequeue: count_next = count + accepted - dequeued.
REQ-029 flush: head, tail, count to 0 at the edge; same-cycle enqueues and dequeues discarded; outputs 0 from next cycle.
REQ-030 flush with upd_hold low still presents current head entries that cycle (combinational), but pointers reset.

Reset
REQ-031 reset asserted: head=0, tail=0, count=0 immediately; all outputs 0, uq_stall=0; entry storage need not clear.
REQ-032 reset asserted mid-operation discards all queued entries; first enqueue after deassertion lands at index 0.

Verification
REQ-033 Single enqueue A: PC=0x100, target=0x200, pred_taken=0, taken=1, idx=5 -> next cycle enA=1, need_take_branchA=1, mispredict_branchA=0, branch_PHT_idxA=5.
REQ-034 Dual enqueue, then upd_hold=1 two cycles -> enA=enB=0, count=2; release -> A=older, B=younger in one cycle, count=0.
REQ-035 Fill to DEPTH-1 with hold high -> uq_stall=1; dual enqueue -> only A accepted, count=DEPTH; further enqueue ignored.
REQ-036 pred_taken=1, taken=1, pred_target=0x300, target=0x340 -> need_take=1, mispredict=0; taken=0 -> mispredict=1, need_take=0.
REQ-037 Cycle >3xDEPTH entries through with random hold -> in-order output, no loss while free>=2, pointer wrap correct.
REQ-038 flush with 5 entries plus concurrent dual enqueue -> next cycle count=0, enA=enB=0; async reset mid-cycle -> outputs 0 before next edge.
